// File: rtl/conv_pkg.sv
// conv_pkg: shared constants for the CONV memory-side responder.
//   - default data/address widths
//   - csel bank encodings and per-bank depths
//   - handshake FSM state enum
//   - bank_depth(): depth for a csel code, 0 for none/invalid codes
package conv_pkg;

    localparam int CONV_DW  = 20;
    localparam int CONV_AW  = 12;
    localparam int NBANK    = 5;

    localparam logic [2:0] CSEL_NONE = 3'b000;
    localparam logic [2:0] CSEL_L0K0 = 3'b001;
    localparam logic [2:0] CSEL_L0K1 = 3'b010;
    localparam logic [2:0] CSEL_L1K0 = 3'b011;
    localparam logic [2:0] CSEL_L1K1 = 3'b100;
    localparam logic [2:0] CSEL_L2   = 3'b101;

    localparam int L0_DEPTH = 4096;
    localparam int L1_DEPTH = 1024;
    localparam int L2_DEPTH = 2048;

    typedef enum logic [1:0] {ST_LOAD, ST_ARM, ST_RUN, ST_DONE} state_e;

    // A zero depth makes every address compare out of range, so the
    // none/invalid codes fall out of the same range check as real banks.
    function automatic int bank_depth(input logic [2:0] sel);
        case (sel)
            CSEL_L0K0, CSEL_L0K1: return L0_DEPTH;
            CSEL_L1K0, CSEL_L1K1: return L1_DEPTH;
            CSEL_L2:              return L2_DEPTH;
            default:              return 0;
        endcase
    endfunction

endpackage

// File: rtl/conv_bank_ram.sv
// conv_bank_ram: single-port-write / async-read memory used for the image
// and each layer bank. Contents are never reset.
//   clk   : clock
//   we    : write enable (address assumed already range-checked)
//   waddr : write address, wdata : write data
//   raddr : read address,  rdata : combinational read data
module conv_bank_ram #(
    parameter int DEPTH = 1024,
    parameter int DW    = 20,
    parameter int AW    = 12
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr[IW-1:0]] <= wdata;
    end

    assign rdata = mem_q[raddr[IW-1:0]];

endmodule

// File: rtl/conv_layer_mem.sv
// conv_layer_mem: image memory + five layer banks + start/finish handshake
// for the CONV accelerator.
//   clk, reset           : clock, synchronous active-high reset
//   ld_valid, ld_data    : host image load (LOAD state only, auto-increment)
//   ready / busy         : image loaded / CONV running handshake
//   iaddr -> idata       : combinational image read
//   cwr, caddr_wr, cdata_wr : layer write (RUN only)
//   crd, caddr_rd -> cdata_rd : layer read, value held while crd=0
//   csel                 : layer bank select
//   done, err            : sticky completion / protocol-error flags
module conv_layer_mem
    import conv_pkg::*;
#(
    parameter int DW        = CONV_DW,
    parameter int AW        = CONV_AW,
    parameter int IMG_DEPTH = 4096
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    output logic          ready,
    input  logic          busy,
    input  logic [AW-1:0] iaddr,
    output logic [DW-1:0] idata,
    input  logic          cwr,
    input  logic [AW-1:0] caddr_wr,
    input  logic [DW-1:0] cdata_wr,
    input  logic          crd,
    input  logic [AW-1:0] caddr_rd,
    output logic [DW-1:0] cdata_rd,
    input  logic [2:0]    csel,
    output logic          done,
    output logic          err
);
    state_e          state_q, state_d;
    logic [AW-1:0]   ld_ptr_q, ld_ptr_d;
    logic            err_q, err_d;
    logic [DW-1:0]   rd_hold_q, rd_val;
    logic [AW:0]     wr_cnt_q [NBANK];
    logic [NBANK-1:0] bank_we;
    logic [DW-1:0]   bank_rd [NBANK];
    logic            img_we, wr_in_range, rd_in_range, wr_ok;

    // ---------------- handshake FSM ----------------
    always_comb begin
        state_d  = state_q;
        ld_ptr_d = ld_ptr_q;
        case (state_q)
            ST_LOAD: if (ld_valid) begin
                ld_ptr_d = ld_ptr_q + 1'b1;
                if (ld_ptr_q == AW'(IMG_DEPTH - 1)) begin
                    state_d  = ST_ARM;
                    ld_ptr_d = '0;
                end
            end
            ST_ARM:  if (busy)  state_d = ST_RUN;
            ST_RUN:  if (!busy) state_d = ST_DONE;
            default: ;
        endcase
    end

    assign ready  = (state_q == ST_ARM);
    assign done   = (state_q == ST_DONE);
    assign err    = err_q;
    assign img_we = (state_q == ST_LOAD) && ld_valid;

    // ---------------- image memory ----------------
    conv_bank_ram #(.DEPTH(IMG_DEPTH), .DW(DW), .AW(AW)) u_img (
        .clk(clk), .we(img_we), .waddr(ld_ptr_q), .wdata(ld_data),
        .raddr(iaddr), .rdata(idata)
    );

    // ---------------- layer banks ----------------
    assign wr_in_range = int'(caddr_wr) < bank_depth(csel);
    assign rd_in_range = int'(caddr_rd) < bank_depth(csel);
    assign wr_ok       = cwr && (state_q == ST_RUN) && wr_in_range;

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        assign bank_we[b] = wr_ok && (csel == 3'(b + 1));
        conv_bank_ram #(.DEPTH(bank_depth(3'(b + 1))), .DW(DW), .AW(AW)) u_bank (
            .clk(clk), .we(bank_we[b]), .waddr(caddr_wr), .wdata(cdata_wr),
            .raddr(caddr_rd), .rdata(bank_rd[b])
        );
    end

    // Out-of-range or invalid-bank reads return 0.
    always_comb begin
        rd_val = '0;
        for (int b = 0; b < NBANK; b++) begin
            if (rd_in_range && csel == 3'(b + 1)) rd_val = bank_rd[b];
        end
    end

    // Live value while crd is high, last read value otherwise.
    assign cdata_rd = crd ? rd_val : rd_hold_q;

    // Simultaneous cwr/crd is flagged even though both sides complete.
    assign err_d = err_q | (cwr && !wr_ok) | (crd && !rd_in_range) | (cwr && crd);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_LOAD;
            ld_ptr_q  <= '0;
            err_q     <= 1'b0;
            rd_hold_q <= '0;
            for (int b = 0; b < NBANK; b++) wr_cnt_q[b] <= '0;
        end else begin
            state_q  <= state_d;
            ld_ptr_q <= ld_ptr_d;
            err_q    <= err_d;
            if (crd) rd_hold_q <= rd_val;
            for (int b = 0; b < NBANK; b++) begin
                if (bank_we[b] && (wr_cnt_q[b] != '1)) wr_cnt_q[b] <= wr_cnt_q[b] + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_conv_layer_mem.sv
module tb_conv_layer_mem;
    import conv_pkg::*;

    localparam int DW  = 20;
    localparam int AW  = 12;
    localparam int IMG = 4096;

    logic          clk = 1'b0;
    logic          reset, ld_valid, busy, cwr, crd;
    logic [DW-1:0] ld_data, cdata_wr;
    logic [AW-1:0] iaddr, caddr_wr, caddr_rd;
    logic [2:0]    csel;
    logic          ready, done, err;
    logic [DW-1:0] idata, cdata_rd;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    conv_layer_mem #(.DW(DW), .AW(AW), .IMG_DEPTH(IMG)) dut (
        .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_data(ld_data),
        .ready(ready), .busy(busy), .iaddr(iaddr), .idata(idata),
        .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
        .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
        .csel(csel), .done(done), .err(err)
    );

    // Stimulus-only helpers (no checking inside).
    task automatic load_image(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            @(negedge clk);
            ld_valid = 1'b1;
            ld_data  = DW'(i);
        end
        @(negedge clk);
        ld_valid = 1'b0;
    endtask

    task automatic wr(input logic [2:0] s, input int a, input logic [DW-1:0] d);
        @(negedge clk);
        cwr = 1'b1; csel = s; caddr_wr = AW'(a); cdata_wr = d;
        @(negedge clk);
        cwr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; ld_valid = 0; ld_data = '0; busy = 0; iaddr = '0;
        cwr = 0; caddr_wr = '0; cdata_wr = '0; crd = 0; caddr_rd = '0; csel = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        vecs++; if (ready !== 1'b0)    begin errs++; $display("FAIL rst_ready got %0b want 0", ready); end
        vecs++; if (done !== 1'b0)     begin errs++; $display("FAIL rst_done got %0b want 0", done); end
        vecs++; if (err !== 1'b0)      begin errs++; $display("FAIL rst_err got %0b want 0", err); end
        vecs++; if (cdata_rd !== '0)   begin errs++; $display("FAIL rst_cdata_rd got %h want 0", cdata_rd); end
        vecs++; if (dut.state_q !== ST_LOAD) begin errs++; $display("FAIL rst_state got %0d want LOAD", dut.state_q); end
        vecs++; if (dut.ld_ptr_q !== '0) begin errs++; $display("FAIL rst_ld_ptr got %0d want 0", dut.ld_ptr_q); end
        vecs++; if (dut.wr_cnt_q[0] !== '0) begin errs++; $display("FAIL rst_cnt got %0d want 0", dut.wr_cnt_q[0]); end
    endtask

    task automatic test_load();
        load_image(0, IMG - 2);
        vecs++; if (ready !== 1'b0) begin errs++; $display("FAIL load_early_ready got %0b want 0", ready); end
        load_image(IMG - 1, IMG - 1);
        vecs++; if (ready !== 1'b1) begin errs++; $display("FAIL load_ready got %0b want 1", ready); end
        iaddr = 12'hFFF; #1;
        vecs++; if (idata !== 20'h00FFF) begin errs++; $display("FAIL load_idata_fff got %h want 00fff", idata); end
        iaddr = 12'h123; #1;
        vecs++; if (idata !== 20'h00123) begin errs++; $display("FAIL load_idata_123 got %h want 00123", idata); end
    endtask

    task automatic test_arm();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vecs++; if (ready !== 1'b1) begin errs++; $display("FAIL arm_ready_level got %0b want 1", ready); end
        end
        ld_valid = 1'b1; ld_data = 20'hABCDE;
        @(negedge clk);
        ld_valid = 1'b0; iaddr = '0; #1;
        vecs++; if (idata !== 20'h00000) begin errs++; $display("FAIL arm_ld_ignored got %h want 00000", idata); end
        busy = 1'b1;
        @(negedge clk);
        vecs++; if (ready !== 1'b0) begin errs++; $display("FAIL arm_ready_fall got %0b want 0", ready); end
        vecs++; if (dut.state_q !== ST_RUN) begin errs++; $display("FAIL arm_state got %0d want RUN", dut.state_q); end
    endtask

    task automatic test_layer_rw();
        wr(CSEL_L1K0, 1023, 20'hFFFFF);
        crd = 1'b1; csel = CSEL_L1K0; caddr_rd = 12'd1023; #1;
        vecs++; if (cdata_rd !== 20'hFFFFF) begin errs++; $display("FAIL rw_readback got %h want fffff", cdata_rd); end
        vecs++; if (err !== 1'b0) begin errs++; $display("FAIL rw_err_clean got %0b want 0", err); end
        vecs++; if (dut.wr_cnt_q[2] !== 13'd1) begin errs++; $display("FAIL rw_cnt got %0d want 1", dut.wr_cnt_q[2]); end
        @(negedge clk); crd = 1'b0;
        wr(CSEL_L1K0, 1024, 20'h00001);
        vecs++; if (err !== 1'b1) begin errs++; $display("FAIL rw_oor_err got %0b want 1", err); end
        vecs++; if (dut.wr_cnt_q[2] !== 13'd1) begin errs++; $display("FAIL rw_oor_cnt got %0d want 1", dut.wr_cnt_q[2]); end
        // read hold
        wr(CSEL_L2, 7, 20'h12345);
        crd = 1'b1; csel = CSEL_L2; caddr_rd = 12'd7; #1;
        vecs++; if (cdata_rd !== 20'h12345) begin errs++; $display("FAIL hold_read got %h want 12345", cdata_rd); end
        @(negedge clk); crd = 1'b0; caddr_rd = 12'd8; #1;
        vecs++; if (cdata_rd !== 20'h12345) begin errs++; $display("FAIL hold_a8 got %h want 12345", cdata_rd); end
        @(negedge clk); caddr_rd = 12'd100; #1;
        vecs++; if (cdata_rd !== 20'h12345) begin errs++; $display("FAIL hold_a100 got %h want 12345", cdata_rd); end
        @(negedge clk); crd = 1'b1; csel = 3'b110; #1;
        vecs++; if (cdata_rd !== 20'h00000) begin errs++; $display("FAIL rd_invalid_sel got %h want 0", cdata_rd); end
        @(negedge clk); crd = 1'b0;
    endtask

    task automatic test_done();
        busy = 1'b0;
        @(negedge clk);
        vecs++; if (done !== 1'b1) begin errs++; $display("FAIL done_rise got %0b want 1", done); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vecs++; if (done !== 1'b1 || ready !== 1'b0) begin errs++; $display("FAIL done_sticky got done=%0b ready=%0b want 1/0", done, ready); end
        end
        crd = 1'b1; csel = CSEL_L1K0; caddr_rd = 12'd1023; #1;
        vecs++; if (cdata_rd !== 20'hFFFFF) begin errs++; $display("FAIL done_dump got %h want fffff", cdata_rd); end
        @(negedge clk); crd = 1'b0;
    endtask

    task automatic test_reset_midrun();
        reset = 1'b1; @(negedge clk); reset = 1'b0;
        load_image(0, IMG - 1);
        busy = 1'b1; @(negedge clk);
        wr(CSEL_L0K0, 5, 20'h00010);
        vecs++; if (dut.wr_cnt_q[0] !== 13'd1) begin errs++; $display("FAIL mid_cnt got %0d want 1", dut.wr_cnt_q[0]); end
        wr(CSEL_L1K0, 2000, 20'h00003);
        vecs++; if (err !== 1'b1) begin errs++; $display("FAIL mid_err_set got %0b want 1", err); end
        reset = 1'b1; @(negedge clk); reset = 1'b0; busy = 1'b0; #1;
        vecs++; if (ready !== 1'b0 || done !== 1'b0) begin errs++; $display("FAIL mid_flags got ready=%0b done=%0b want 0/0", ready, done); end
        vecs++; if (err !== 1'b0) begin errs++; $display("FAIL mid_err_clr got %0b want 0", err); end
        vecs++; if (dut.state_q !== ST_LOAD) begin errs++; $display("FAIL mid_state got %0d want LOAD", dut.state_q); end
        vecs++; if (dut.wr_cnt_q[0] !== '0) begin errs++; $display("FAIL mid_cnt_clr got %0d want 0", dut.wr_cnt_q[0]); end
        ld_valid = 1'b1; ld_data = 20'h55555;
        @(negedge clk);
        ld_valid = 1'b0; iaddr = '0; #1;
        vecs++; if (idata !== 20'h55555) begin errs++; $display("FAIL mid_reload got %h want 55555", idata); end
        vecs++; if (dut.ld_ptr_q !== 12'd1) begin errs++; $display("FAIL mid_ld_ptr got %0d want 1", dut.ld_ptr_q); end
    endtask

    task automatic test_collision();
        load_image(1, IMG - 1);
        busy = 1'b1; @(negedge clk);
        crd = 1'b1; csel = CSEL_L0K0; caddr_rd = 12'd5; #1;
        vecs++; if (cdata_rd !== 20'h00010) begin errs++; $display("FAIL col_old got %h want 00010", cdata_rd); end
        vecs++; if (err !== 1'b0) begin errs++; $display("FAIL col_err_pre got %0b want 0", err); end
        cwr = 1'b1; caddr_wr = 12'd5; cdata_wr = 20'h00020; #1;
        vecs++; if (cdata_rd !== 20'h00010) begin errs++; $display("FAIL col_prewrite got %h want 00010", cdata_rd); end
        @(negedge clk); cwr = 1'b0; #1;
        vecs++; if (err !== 1'b1) begin errs++; $display("FAIL col_err got %0b want 1", err); end
        vecs++; if (cdata_rd !== 20'h00020) begin errs++; $display("FAIL col_new got %h want 00020", cdata_rd); end
        vecs++; if (dut.wr_cnt_q[0] !== 13'd1) begin errs++; $display("FAIL col_cnt got %0d want 1", dut.wr_cnt_q[0]); end
        @(negedge clk); crd = 1'b0; busy = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_load();
        test_arm();
        test_layer_rw();
        test_done();
        test_reset_midrun();
        test_collision();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/conv_layer_mem.md
# conv_layer_mem

Memory-side responder for the CONV accelerator. It holds the 64x64 grayscale input image and the five layer result banks, answers the accelerator's image-read port (`iaddr`/`idata`) and its layer read/write port (`cwr`/`crd`/`csel`), and runs the start/finish handshake (`ready`/`busy`). It sits between the host loader and CONV, and is used both as the synthesizable memory wrapper and as the verification golden-memory.

## Interface
- `DW`, 20: data width; pixels and layer values are signed Q-format, 20 bits.
- `AW`, 12: address width.
- `IMG_DEPTH`, 4096: number of image words loaded before `ready` is raised.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `ld_valid` input 1: host pixel strobe, accepted only in LOAD.
- `ld_data` input DW: host pixel, written at auto-incremented address.
- `ready` output 1: image loaded; CONV may start.
- `busy` input 1: CONV running.
- `iaddr` input AW: image read address.
- `idata` output DW: image word at `iaddr`.
- `cwr` input 1: layer write strobe.
- `caddr_wr` input AW: layer write address.
- `cdata_wr` input DW: layer write data.
- `crd` input 1: layer read strobe.
- `caddr_rd` input AW: layer read address.
- `cdata_rd` output DW: layer read data.
- `csel` input 3: bank select.
- `done` output 1: sticky; CONV completed.
- `err` output 1: sticky protocol-error flag.

## Operation
- Banks by `csel`: 000 none; 001 L0 kernel0 (4096); 010 L0 kernel1 (4096); 011 L1 kernel0 (1024); 100 L1 kernel1 (1024); 101 L2 flatten (2048); 110/111 invalid.
- FSM states: LOAD, ARM, RUN, DONE. Reset -> LOAD.
- LOAD: each `ld_valid` cycle writes `ld_data` to image[ld_ptr], ld_ptr++; when the write at ld_ptr = IMG_DEPTH-1 occurs -> ARM. `ld_valid` outside LOAD is ignored.
- ARM: `ready`=1 (level, not pulse) until `busy`=1 is sampled, then -> RUN with `ready`=0 the same edge.
- RUN: services reads/writes; `busy` sampled 0 -> DONE.
- DONE: `done`=1 until reset; the layer port stays serviceable so the bench can dump banks.
- Image read: `idata` = image[`iaddr`] combinationally, all states.
- Layer write: on edge with `cwr`=1 and valid `csel`, bank[caddr_wr] <= cdata_wr. Write with address >= bank depth, `csel` invalid/000, or outside RUN: no write, `err` set.
- Layer read: with `crd`=1, `cdata_rd` = bank[caddr_rd] combinationally; with `crd`=0, `cdata_rd` holds the last value driven under `crd`=1 (registered hold). Out-of-range read returns 0 and sets `err`.
- `cwr` and `crd` both 1 in one cycle: `err` set; the write commits at the edge; the read returns pre-write contents.
- Per-bank write counters (width AW+1, saturating) readable by the bench hierarchically.

## Timing
- Reset values: `ready`=0, `done`=0, `err`=0, `cdata_rd`=0, ld_ptr=0, counters=0, state LOAD. Memory contents are not cleared.
- Load latency: `ready` rises the edge after the IMG_DEPTH-th accepted `ld_valid`.
- `ready` falls on the edge that samples `busy`=1; `done` rises on the edge that samples `busy`=0 in RUN.
- Read latency 0 cycles (combinational) for both ports; writes visible to a read in the following cycle.
- Reset mid-operation: FSM returns to LOAD, flags and counters clear, and the image must be reloaded.

## Structure
- Shared package `conv_pkg`: DW/AW constants, `csel` encodings, bank-depth constants (4096/1024/2048), FSM state enum.
- One sub-module `conv_bank_ram` (parameterized depth, async read, sync write), instantiated once for the image and once per layer bank.

## Test plan
- Load 4096 pixels (value = address) -> `ready`=1 one edge after the last; `idata` at `iaddr`=0x0FFF reads 0x00FFF.
- `ready`=1, then drive `busy`=1 -> `ready`=0 next edge; `busy`=0 three cycles later -> `done`=1 and stays 1.
- In RUN: write 0xFFFFF to `csel`=011 addr 1023, then read it back -> 0xFFFFF; write to `csel`=011 addr 1024 -> no write, `err`=1.
- `cwr`=1 and `crd`=1 to the same `csel`=001 addr 5 (old 0x00010, new 0x00020) -> `cdata_rd`=0x00010, `err`=1, next read returns 0x00020.
- Assert `reset` for one cycle during RUN -> next cycle `ready`=0, `done`=0, `err`=0, state LOAD; `ld_valid` is accepted again from address 0.
- `crd`=0 after reading 0x12345 -> `cdata_rd` holds 0x12345 while `caddr_rd` changes.
